// File: rtl/s2_cfg_pkg.sv
// Shared definitions for the S2 cell-column configuration controller.
// Holds the controller state encoding, the bitstream header pattern,
// the per-cell config width and a state-class helper.
package s2_cfg_pkg;

    // Config bits per S2 cell: {D11,D10,D01,D00}
    localparam int CFG_BITS = 4;

    // Default bitstream header value (sent LSB first)
    localparam logic [3:0] SYNC_PAT = 4'b1010;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SYNC   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_CHECK  = 3'd3,
        ST_ACTIVE = 3'd4,
        ST_ERROR  = 3'd5
    } state_t;

    // True for the states that consume serial bits
    function automatic logic is_rx_state(input state_t s);
        return (s == ST_SYNC) || (s == ST_LOAD) || (s == ST_CHECK);
    endfunction

endpackage

// File: rtl/s2_cfg_shift.sv
// Serial-to-parallel shadow register for the cell configuration payload.
// Bits arrive LSB first, cell 0 first, so shifting in from the top leaves
// stream bit k at shadow bit k once all NCELL*4 bits have been taken.
// Ports:
//   clk, clr  : clock, async active-high reset
//   clear_i   : synchronous clear of shadow, accumulator and bit counter
//   shift_i   : accept bit_i this cycle
//   bit_i     : serial data bit
//   shadow_o  : assembled payload
//   xor_o     : XOR of all nibbles received so far
//   last_o    : the next accepted bit is the final payload bit
module s2_cfg_shift
    import s2_cfg_pkg::*;
#(
    parameter int NCELL = 8
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      clear_i,
    input  logic                      shift_i,
    input  logic                      bit_i,
    output logic [NCELL*CFG_BITS-1:0] shadow_o,
    output logic [3:0]                xor_o,
    output logic                      last_o
);

    localparam int NB = NCELL * CFG_BITS;
    localparam int CW = $clog2(NB);

    logic [NB-1:0] shadow_q, shadow_d;
    logic [3:0]    xor_q, xor_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Next-state: the nibble XOR is folded per bit position, which equals
    // XOR-ing each completed nibble without buffering the nibble itself.
    always_comb begin
        shadow_d = shadow_q;
        xor_d    = xor_q;
        cnt_d    = cnt_q;
        if (clear_i) begin
            shadow_d = {NB{1'b0}};
            xor_d    = 4'h0;
            cnt_d    = {CW{1'b0}};
        end else if (shift_i) begin
            shadow_d            = {bit_i, shadow_q[NB-1:1]};
            xor_d[cnt_q[1:0]]   = xor_q[cnt_q[1:0]] ^ bit_i;
            cnt_d               = (cnt_q == CW'(NB - 1)) ? {CW{1'b0}} : cnt_q + CW'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            shadow_q <= {NB{1'b0}};
            xor_q    <= 4'h0;
            cnt_q    <= {CW{1'b0}};
        end else begin
            shadow_q <= shadow_d;
            xor_q    <= xor_d;
            cnt_q    <= cnt_d;
        end
    end

    assign shadow_o = shadow_q;
    assign xor_o    = xor_q;
    assign last_o   = (cnt_q == CW'(NB - 1));

endmodule

// File: rtl/s2_config_ctrl.sv
// Configuration and ld-sequencing controller for a column of NCELL S2 cells.
// Receives header + payload + checksum serially, publishes the checked
// config, then drives cell ld strobes (broadcast or single-step).
// Ports:
//   clk, clr              : clock, async active-high reset
//   start                 : begin (re)configuration (IDLE/ACTIVE/ERROR)
//   bit_in/bit_valid/bit_ready : serial config handshake
//   cfg, cfg_valid        : live config, cell i at cfg[4i+3:4i]
//   run_en, step          : broadcast mode / single-step request
//   cell_ld               : per-cell ld strobes
//   busy, done, err       : receiving, load-complete pulse, sticky error
module s2_config_ctrl
    import s2_cfg_pkg::*;
#(
    parameter int         NCELL = 8,
    parameter logic [3:0] SYNC  = SYNC_PAT
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      start,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    output logic                      bit_ready,
    output logic [NCELL*CFG_BITS-1:0] cfg,
    output logic                      cfg_valid,
    input  logic                      run_en,
    input  logic                      step,
    output logic [NCELL-1:0]          cell_ld,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int NB = NCELL * CFG_BITS;
    localparam int PW = (NCELL > 1) ? $clog2(NCELL) : 1;

    state_t         state_q, state_d;
    logic [1:0]     nib_q, nib_d;
    logic [3:0]     rx_q, rx_d;
    logic [NB-1:0]  cfg_q, cfg_d;
    logic           cfg_valid_q, cfg_valid_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [NCELL-1:0] cell_ld_q, cell_ld_d;
    logic           done_q, done_d;
    logic           bit_ready_q, busy_q, err_q;

    logic           accept_s, clear_s, shift_s, last_s;
    logic [3:0]     rx_next_s, xor_s;
    logic [NB-1:0]  shadow_s;

    assign accept_s  = bit_valid & bit_ready_q;
    assign rx_next_s = {bit_in, rx_q[3:1]};

    s2_cfg_shift #(.NCELL(NCELL)) u_shift (
        .clk      (clk),
        .clr      (clr),
        .clear_i  (clear_s),
        .shift_i  (shift_s),
        .bit_i    (bit_in),
        .shadow_o (shadow_s),
        .xor_o    (xor_s),
        .last_o   (last_s)
    );

    // FSM next-state, config commit and ld sequencing
    always_comb begin
        state_d     = state_q;
        nib_d       = nib_q;
        rx_d        = rx_q;
        cfg_d       = cfg_q;
        cfg_valid_d = cfg_valid_q;
        ptr_d       = ptr_q;
        cell_ld_d   = {NCELL{1'b0}};
        done_d      = 1'b0;
        clear_s     = 1'b0;
        shift_s     = 1'b0;
        case (state_q)
            ST_IDLE, ST_ERROR: begin
                if (start) begin
                    state_d = ST_SYNC;
                    nib_d   = 2'd0;
                    clear_s = 1'b1;
                end else begin
                    state_d = state_q;
                end
            end
            ST_SYNC: begin
                if (accept_s) begin
                    rx_d = rx_next_s;
                    if (nib_q == 2'd3) begin
                        nib_d   = 2'd0;
                        state_d = (rx_next_s == SYNC) ? ST_LOAD : ST_ERROR;
                    end else begin
                        nib_d = nib_q + 2'd1;
                    end
                end else begin
                    nib_d = nib_q;
                end
            end
            ST_LOAD: begin
                if (accept_s) begin
                    shift_s = 1'b1;
                    state_d = last_s ? ST_CHECK : ST_LOAD;
                end else begin
                    shift_s = 1'b0;
                end
            end
            ST_CHECK: begin
                if (accept_s) begin
                    rx_d = rx_next_s;
                    if (nib_q == 2'd3) begin
                        nib_d = 2'd0;
                        // The accumulator already includes the final nibble here
                        if (rx_next_s == xor_s) begin
                            cfg_d       = shadow_s;
                            cfg_valid_d = 1'b1;
                            done_d      = 1'b1;
                            state_d     = ST_ACTIVE;
                        end else begin
                            state_d = ST_ERROR;
                        end
                    end else begin
                        nib_d = nib_q + 2'd1;
                    end
                end else begin
                    nib_d = nib_q;
                end
            end
            ST_ACTIVE: begin
                // start outranks run_en and step; old cfg stays visible
                if (start) begin
                    cfg_valid_d = 1'b0;
                    ptr_d       = {PW{1'b0}};
                    nib_d       = 2'd0;
                    clear_s     = 1'b1;
                    state_d     = ST_SYNC;
                end else if (run_en) begin
                    cell_ld_d = {NCELL{1'b1}};
                end else if (step) begin
                    cell_ld_d = {{(NCELL-1){1'b0}}, 1'b1} << ptr_q;
                    ptr_d     = (ptr_q == PW'(NCELL - 1)) ? {PW{1'b0}} : ptr_q + PW'(1);
                end else begin
                    cell_ld_d = {NCELL{1'b0}};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs; status flags follow the next state
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            nib_q       <= 2'd0;
            rx_q        <= 4'h0;
            cfg_q       <= {NB{1'b0}};
            cfg_valid_q <= 1'b0;
            ptr_q       <= {PW{1'b0}};
            cell_ld_q   <= {NCELL{1'b0}};
            done_q      <= 1'b0;
            bit_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nib_q       <= nib_d;
            rx_q        <= rx_d;
            cfg_q       <= cfg_d;
            cfg_valid_q <= cfg_valid_d;
            ptr_q       <= ptr_d;
            cell_ld_q   <= cell_ld_d;
            done_q      <= done_d;
            bit_ready_q <= is_rx_state(state_d);
            busy_q      <= is_rx_state(state_d);
            err_q       <= (state_d == ST_ERROR);
        end
    end

    assign bit_ready = bit_ready_q;
    assign busy      = busy_q;
    assign cfg       = cfg_q;
    assign cfg_valid = cfg_valid_q;
    assign cell_ld   = cell_ld_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/s2_config_ctrl.md
Name: s2_config_ctrl

Overview:
- Configuration and sequencing controller for a column of NCELL S2-type logic cells (4:1 data mux plus clr/ld flip-flop).
- Accepts a serial configuration bitstream over a valid/ready handshake, checks it, and publishes the D00..D11 constants for every cell.
- Once configured, drives the per-cell ld strobes: broadcast in run mode, one cell per step in single-step mode.

Parameters:
- NCELL, 8, number of S2 cells controlled (2..32).
- CFG_BITS, 4, config bits per cell (D00,D01,D10,D11); fixed at 4, not to be overridden.
- SYNC, 4'b1010, bitstream header pattern.

Ports:
- clk  in  1  clock, rising edge.
- clr  in  1  reset, asynchronous, active-high.
- start  in  1  begin (re)configuration; sampled in IDLE, ACTIVE and ERROR.
- bit_in  in  1  serial config bit.
- bit_valid  in  1  bit_in valid.
- bit_ready  out  1  controller accepts a bit this cycle.
- cfg  out  NCELL*4  live config; cell i uses cfg[4i+3:4i] = {D11,D10,D01,D00}.
- cfg_valid  out  1  cfg holds a checked configuration.
- run_en  in  1  broadcast-load mode.
- step  in  1  single-step request, one cycle wide.
- cell_ld  out  NCELL  ld strobe per cell.
- busy  out  1  SYNC, LOAD or CHECK state.
- done  out  1  one-cycle pulse on entry to ACTIVE.
- err  out  1  sticky error flag.

Behaviour:
- Reset (clr=1, any state, including mid-load): state IDLE; cfg, shadow, XOR accumulator, step pointer and bit counter cleared. All outputs 0.
- A bit is accepted only when bit_valid and bit_ready are both 1 on a rising edge. bit_ready is a registered function of state only: 1 in SYNC, LOAD and CHECK, else 0.
- Bit order: each field LSB first. Cell 0 first, then cell 1, up to cell NCELL-1.
- States:
  - IDLE: start -> SYNC.
  - SYNC: accept 4 bits. If they equal SYNC -> LOAD, else -> ERROR. There is no sliding-window hunt.
  - LOAD: accept NCELL*4 bits into the shadow register. Keep a running 4-bit XOR of every completed nibble. After the last bit -> CHECK.
  - CHECK: accept 4 bits and compare them with the XOR accumulator (including the final nibble).
    - Match: the next edge copies shadow to cfg, sets cfg_valid=1, pulses done for one cycle, and enters ACTIVE.
    - Mismatch: -> ERROR; cfg and cfg_valid are left unchanged.
  - ACTIVE, cell_ld registered, one cycle after the causing input:
    - run_en=1: cell_ld = all ones every cycle; step is ignored.
    - run_en=0 and step=1: cell_ld is one-hot at the step pointer for one cycle. The pointer then increments, wrapping from NCELL-1 to 0.
    - run_en=0 and step=0: cell_ld = 0.
    - start has priority over run_en and step: cell_ld = 0 that cycle, cfg_valid drops to 0, pointer resets to 0, -> SYNC. cfg keeps its old contents until a new CHECK passes.
  - ERROR: err=1 (sticky), cell_ld=0. start clears err and -> SYNC.
- bit_valid=0 stalls any receive state indefinitely; counters hold.
- start while busy is ignored.
- step and run_en outside ACTIVE are ignored.
- Counter widths: the bit counter covers 0..NCELL*4-1; the pointer is clog2(NCELL) bits.

Decomposition:
- Shared package s2_cfg_pkg: state enum (IDLE, SYNC, LOAD, CHECK, ACTIVE, ERROR), SYNC constant, CFG_BITS=4.
- One sub-module, s2_cfg_shift: serial-to-parallel shadow register with nibble XOR accumulator and a last-bit flag.
- The FSM and ld sequencer stay in the top module.

Test Plan:
- Good load, NCELL=8: SYNC 1010, nibbles 0x1..0x8, checksum 0x8 (XOR of 1..8) -> done pulses once, cfg=32'h87654321, cfg_valid=1, err=0, busy falls.
- Bad checksum 0x7 after the same data -> ERROR, err=1, cfg_valid=0, cfg=0. A following start plus good stream -> err clears and the config loads.
- Bad header 1011 -> ERROR after exactly 4 accepted bits; bit_ready=0 afterwards.
- ACTIVE, run_en=0, ten step pulses -> cell_ld = 01,02,04..80,01,02, one cycle after each step. Set run_en=1 -> cell_ld=FF every cycle.
- bit_valid toggled randomly 50% during load -> same cfg as the unthrottled run. clr asserted mid-LOAD -> all outputs 0 immediately; IDLE on release.
- Reconfigure: start in ACTIVE -> cfg_valid=0 the next cycle, old cfg held. New stream with nibbles 0xF..0x8, checksum 0x0 -> cfg=32'h89ABCDEF, pointer restarts at cell 0.
